// File: rtl/lcd_timing_pkg.sv
// Shared timing constants and FSM state type for the character-LCD byte path.
// The clock counter and the byte transmitter both take END_CNT from here.
package lcd_timing_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_E_DEF     = 12;
  localparam int unsigned T_GAP_DEF   = 50;
  localparam int unsigned END_CNT_DEF = 2080;

  localparam logic [11:0] E1_LO     = 12'd2;
  localparam logic [11:0] E1_HI     = 12'd13;
  localparam logic [11:0] LOW_START = 12'd65;
  localparam logic [11:0] E2_LO     = 12'd67;
  localparam logic [11:0] E2_HI     = 12'd78;
  localparam logic [11:0] END_CNT   = 12'd2080;

  function automatic logic in_window(input logic [11:0] k,
                                     input logic [11:0] lo,
                                     input logic [11:0] hi);
    return (k >= lo) && (k <= hi);
  endfunction

endpackage

// File: rtl/lcd_phase_decoder.sv
// Maps the clock-counter value to the next E-strobe level and the nibble select.
// Counts past the lower-nibble start, including out-of-range values, fall into the settle window.
module lcd_phase_decoder
  import lcd_timing_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_E     = T_E_DEF,
  parameter int unsigned T_GAP   = T_GAP_DEF
) (
  input  logic [11:0] clk_cnt,
  output logic        e_next,
  output logic        sel_low
);

  localparam int unsigned LOW_START_I = T_SETUP + T_E + 1 + T_GAP;
  localparam logic [11:0] E1_LO_C  = 12'(T_SETUP);
  localparam logic [11:0] E1_HI_C  = 12'(T_SETUP + T_E - 1);
  localparam logic [11:0] LOW_C    = 12'(LOW_START_I);
  localparam logic [11:0] E2_LO_C  = 12'(LOW_START_I + T_SETUP);
  localparam logic [11:0] E2_HI_C  = 12'(LOW_START_I + T_SETUP + T_E - 1);

  // Window decode of the current count
  always_comb begin
    e_next  = 1'b0;
    sel_low = 1'b0;
    e_next  = in_window(clk_cnt, E1_LO_C, E1_HI_C) || in_window(clk_cnt, E2_LO_C, E2_HI_C);
    sel_low = (clk_cnt >= LOW_C);
  end

endmodule

// File: rtl/lcd_byte_transmitter.sv
// Sends one byte over the 4-bit LCD bus as two E-strobed nibbles, pacing itself
// off the external clock counter whose enable it owns.
module lcd_byte_transmitter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_E     = T_E_DEF,
  parameter int unsigned T_GAP   = T_GAP_DEF,
  parameter int unsigned END_CNT = END_CNT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] clk_cnt,
  output logic        cnt_enable,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_rs,
  output logic        tx_done,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [3:0]  lcd_data
);

  localparam logic [11:0] END_CNT_C = 12'(END_CNT);

  tx_state_e   state_q;
  logic [7:0]  data_q;
  logic        rs_q;
  logic        lcd_e_q;
  logic        lcd_rs_q;
  logic [3:0]  lcd_data_q;
  logic        tx_done_q;
  logic        e_next;
  logic        sel_low;

  lcd_phase_decoder #(
    .T_SETUP (T_SETUP),
    .T_E     (T_E),
    .T_GAP   (T_GAP)
  ) u_decoder (
    .clk_cnt (clk_cnt),
    .e_next  (e_next),
    .sel_low (sel_low)
  );

  // Handshake FSM plus the LCD pin registers, which lag clk_cnt by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= 8'h00;
      rs_q       <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 4'h0;
      tx_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          lcd_e_q   <= 1'b0;
          tx_done_q <= 1'b0;
          if (tx_valid) begin
            data_q  <= tx_data;
            rs_q    <= tx_rs;
            state_q <= SEND;
          end else begin
            state_q <= IDLE;
          end
        end
        SEND: begin
          lcd_e_q    <= e_next;
          lcd_rs_q   <= rs_q;
          lcd_data_q <= sel_low ? data_q[3:0] : data_q[7:4];
          if (clk_cnt == END_CNT_C) begin
            state_q   <= IDLE;
            tx_done_q <= 1'b1;
          end else begin
            state_q   <= SEND;
            tx_done_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          lcd_e_q   <= 1'b0;
          tx_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_enable = (state_q == SEND);
  assign tx_ready   = (state_q == IDLE);
  assign tx_done    = tx_done_q;
  assign lcd_e      = lcd_e_q;
  assign lcd_rs     = lcd_rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = lcd_data_q;

endmodule
